// File: rtl/transpose_pp.sv
// transpose_pp: N x N row-in / column-out transpose buffer with ping-pong banks.
// One bank drains columns while the other accepts the next block's rows, so
// a continuous stream moves at one beat per cycle. A per-block bypass flag,
// sampled on row 0, makes the bank emit its rows unchanged instead.
module transpose_pp #(
    parameter int W = 12,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_bypass,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           out_last
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Row storage: mem[bank][row] holds one packed input row.
    logic [N*W-1:0] mem [2][N];

    logic [1:0]    full;
    logic [1:0]    byp;
    logic          wbank;
    logic          rbank;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] rcnt;
    logic          in_fire;
    logic          out_fire;
    logic [N*W-1:0] rrow;

    // Handshakes depend only on registered bank state, never on valid/ready inputs.
    assign in_ready  = ~full[wbank];
    assign out_valid = full[rbank];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && (rcnt == LAST);

    // Store accepted rows; storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wbank][wcnt] <= in_data;
        end
    end

    // Bank state, pointers and counters for both sides. A bank being written is
    // never the one being drained, so the two full[] updates never collide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full  <= 2'b00;
            byp   <= 2'b00;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
        end else begin
            if (in_fire) begin
                if (wcnt == '0) begin
                    byp[wbank] <= in_bypass;
                end
                if (wcnt == LAST) begin
                    full[wbank] <= 1'b1;
                    wcnt        <= '0;
                    wbank       <= ~wbank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (out_fire) begin
                if (rcnt == LAST) begin
                    full[rbank] <= 1'b0;
                    rcnt        <= '0;
                    rbank       <= ~rbank;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end

    // Output mux: column rcnt gathered across rows, or row rcnt in bypass; zero when idle.
    always_comb begin
        out_data = '0;
        rrow     = '0;
        if (out_valid) begin
            if (byp[rbank]) begin
                out_data = mem[rbank][rcnt];
            end else begin
                for (int r = 0; r < N; r++) begin
                    rrow                = mem[rbank][r];
                    out_data[W*r +: W]  = rrow[W*int'(rcnt) +: W];
                end
            end
        end
    end

endmodule

// File: tb/tb_transpose_pp.sv
// Randomized and directed bench for transpose_pp against a block-level reference model.
module tb_transpose_pp;

    localparam int W  = 12;
    localparam int N  = 8;
    localparam int NW = N * W;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_data;
    logic          in_bypass;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_data;
    logic          out_last;

    transpose_pp #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: rows of the block being collected, then whole expected beats.
    logic [NW-1:0] mrows [N];
    int            mrow = 0;
    logic          mbyp = 1'b0;
    logic [NW-1:0] q [$];
    int            ocnt = 0;

    // Producer state
    logic [NW-1:0] row_d;
    int            prow = 0;
    int            pblk = 0;
    bit            pat_mode = 1'b1;

    // Per-test observation flags
    bit  chk_beat0 = 1'b0;
    bit  b2b_mode  = 1'b0;
    int  stepn     = 0;
    int  first_fire;
    int  last_fire;
    int  nfire;
    logic [NW-1:0] beat0_exp;

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] pat(input int b, input int r);
        logic [NW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[W*c +: W] = W'(256*b + 16*r + c);
        return v;
    endfunction

    task automatic next_row();
        if (pat_mode) row_d = pat(pblk, prow);
        else begin
            for (int c = 0; c < N; c++) row_d[W*c +: W] = W'($urandom);
        end
    endtask

    // Model: a completed block produces N beats, either the rows themselves or its columns.
    task automatic model_accept(input logic [NW-1:0] d, input logic b);
        logic [NW-1:0] beat;
        logic [NW-1:0] rr;
        if (mrow == 0) mbyp = b;
        mrows[mrow] = d;
        mrow++;
        if (mrow == N) begin
            for (int k = 0; k < N; k++) begin
                if (mbyp) beat = mrows[k];
                else begin
                    beat = '0;
                    for (int r = 0; r < N; r++) begin
                        rr = mrows[r];
                        beat[W*r +: W] = rr[W*k +: W];
                    end
                end
                q.push_back(beat);
            end
            mrow = 0;
        end
    endtask

    task automatic step(input bit iv, input bit orr, input bit byp);
        int held;
        @(negedge clk);
        in_valid  = iv;
        out_ready = orr;
        in_bypass = byp;
        in_data   = row_d;
        #1;
        held = (q.size() + N - 1) / N;
        chk("in_ready", NW'(in_ready), NW'(held < 2));
        chk("out_valid", NW'(out_valid), NW'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0]);
            chk("out_last", NW'(out_last), NW'((ocnt % N) == N - 1));
            if (chk_beat0 && ocnt == 0) chk("single_beat0", out_data, beat0_exp);
        end else begin
            chk("out_data_idle", out_data, '0);
            chk("out_last_idle", NW'(out_last), '0);
        end
        if (b2b_mode && iv) chk("b2b_in_ready", NW'(in_ready), NW'(1));
        if (out_valid && out_ready) begin
            if (q.size() != 0) void'(q.pop_front());
            ocnt++;
            if (nfire == 0) first_fire = stepn;
            last_fire = stepn;
            nfire++;
        end
        if (in_valid && in_ready) begin
            model_accept(in_data, in_bypass);
            prow++;
            if (prow == N) begin
                prow = 0;
                pblk++;
            end
            next_row();
        end
        stepn++;
    endtask

    // Offer blocks up to absolute index lim, then drain; bmode 2 picks a random flag per row.
    task automatic run(input int lim, input int vpct, input int rpct, input int bmode,
                       input bit toggle, input int max_steps);
        int  n;
        bit  iv, orr, b;
        n = 0;
        while ((pblk < lim || q.size() != 0 || mrow != 0) && n < max_steps) begin
            iv  = (pblk < lim) && ($urandom_range(99) < vpct);
            orr = ($urandom_range(99) < rpct);
            if (bmode == 2) b = 1'($urandom);
            else b = (toggle && prow != 0) ? ~bmode[0] : bmode[0];
            step(iv, orr, b);
            n++;
        end
        if (n >= max_steps) chk("timeout", NW'(0), NW'(1));
    endtask

    initial begin
        rstn      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bypass = 1'b0;
        in_data   = '0;
        next_row();
        beat0_exp = '0;
        for (int r = 0; r < N; r++) beat0_exp[W*r +: W] = W'(16*r);
        #2 rstn = 1'b0;
        #1;
        chk("rst_in_ready", NW'(in_ready), NW'(1));
        chk("rst_out_valid", NW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", NW'(out_last), '0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Single block with pattern 16*r+c
        chk_beat0 = 1'b1;
        run(1, 100, 100, 0, 1'b0, 200);
        chk_beat0 = 1'b0;

        // Back-to-back: four blocks, no bubbles
        b2b_mode = 1'b1;
        stepn = 0; nfire = 0; first_fire = -1; last_fire = -1;
        run(5, 100, 100, 0, 1'b0, 200);
        b2b_mode = 1'b0;
        chk("b2b_nbeats", NW'(nfire), NW'(32));
        chk("b2b_first", NW'(first_fire), NW'(8));
        chk("b2b_last", NW'(last_fire), NW'(39));

        // Backpressure: three blocks offered, two fit
        for (int i = 0; i < 30; i++) step(pblk < 8, 1'b0, 1'b0);
        chk("bp_blocks", NW'(pblk), NW'(7));
        chk("bp_in_ready", NW'(in_ready), '0);
        chk("bp_held_beats", NW'(q.size()), NW'(16));
        run(8, 100, 100, 0, 1'b0, 200);

        // Bypass block then transposed block, bypass input toggled mid-block
        run(9, 100, 100, 1, 1'b1, 200);
        run(10, 100, 100, 0, 1'b1, 200);

        // Random valid/ready over 200 blocks with random data
        pat_mode = 1'b0;
        next_row();
        run(210, 50, 50, 2, 1'b0, 20000);

        // Reset in the middle of operation
        pat_mode = 1'b1;
        next_row();
        run(211, 100, 100, 0, 1'b0, 200);
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_in_ready", NW'(in_ready), NW'(1));
        chk("mid_rst_out_valid", NW'(out_valid), '0);
        chk("mid_rst_out_data", out_data, '0);
        q.delete();
        mrow = 0;
        ocnt = 0;
        prow = 0;
        pblk = pblk + 1;
        next_row();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run(pblk + 1, 100, 100, 0, 1'b0, 200);
        run(pblk + 2, 60, 60, 0, 1'b0, 500);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/transpose_pp.md
# transpose_pp

Parametrised N×N row-in / column-out transpose buffer with ping-pong double buffering and valid/ready handshakes on both sides, for the JPEG DCT datapath between the row (1-D) DCT pass and the column pass. While one bank drains columns, the other accepts the next block's rows, so sustained throughput is one beat per cycle with no bubbles. A per-block bypass mode passes rows through unchanged for pipeline debug and for non-transposing consumers.

## Interface

- W, default 12: element width in bits.
- N, default 8: block dimension, giving N rows × N elements per block. Legal values are 2 to 16.
- clk  in  1: clock, rising edge.
- rstn  in  1: asynchronous active-low reset.
- in_valid  in  1: producer has a row on in_data.
- in_ready  out  1: a row beat is accepted when in_valid && in_ready.
- in_data  in  N*W: one row. Element at column i sits at bits [W*i +: W].
- in_bypass  in  1: mode for a block, sampled on that block's first row (row 0).
- out_valid  out  1: out_data holds a valid beat.
- out_ready  in  1: a beat is consumed when out_valid && out_ready.
- out_data  out  N*W: one column, with element from row r at bits [W*r +: W]. In bypass mode it carries one row in input packing.
- out_last  out  1: high on the final (N-th) beat of a block.

## Operation

- Storage: two banks, each N×N×W, plus one bypass flag per bank.
- Per-bank state: EMPTY or FULL. A single bank index pointer exists on each side:
  - write side: wbank and row counter wcnt in 0..N-1;
  - read side: rbank and beat counter rcnt in 0..N-1.
- in_ready = (bank[wbank] is EMPTY).
- On each accepted input beat:
  - in_data is stored as row wcnt of bank wbank;
  - if wcnt==0, in_bypass is latched into that bank's flag;
  - wcnt increments.
  - When wcnt==N-1 is accepted: bank[wbank] becomes FULL, wcnt returns to 0, and wbank toggles.
- out_valid = (bank[rbank] is FULL).
- out_data lane r:
  - transpose mode: element (row r, column rcnt) of bank rbank;
  - bypass mode: out_data = row rcnt of bank rbank.
- out_last = out_valid && rcnt==N-1.
- On each consumed output beat, rcnt increments. When rcnt==N-1 is consumed: bank[rbank] becomes EMPTY, rcnt returns to 0, and rbank toggles.
- When out_valid is 0, out_data is driven to all zeros.
- Storage contents are not reset. Only state, counters and pointers are reset.
- Simultaneous events:
  - Write into one bank and read from the other in the same cycle is always legal.
  - A bank freed by its last read becomes EMPTY at the next edge, and the writer may then accept into it. There is no same-cycle write-through.
  - A bank filled by its last write becomes FULL at the next edge.
- in_valid with in_ready low is a stall. in_data is not stored and the counters hold.
- out_valid stays asserted and out_data stays stable until consumed, regardless of input-side activity.

## Timing

- Reset, asynchronous on rstn low, gives:
  - both banks EMPTY; wbank=rbank=0; wcnt=rcnt=0;
  - in_ready=1, out_valid=0, out_last=0, out_data=0.
- Reset mid-block discards all partial and full blocks. After rstn rises, the first accepted beat is row 0 of bank 0.
- Latency: when row N-1 is accepted at edge t, out_valid rises after edge t (combinational from registered state) and the first beat can be consumed at edge t+1.
- Throughput: with in_valid and out_ready held high, the block sustains 1 beat/cycle in and out after the initial N-cycle fill.
- in_ready falls only when both banks are FULL, or when the write bank is still draining.
- All outputs derive from registers plus the storage read mux. There is no combinational path from in_valid/in_data to any output, and none from out_ready to any output.

## Test plan

- Single block, W=12, N=8: send rows with element(r,c)=16*r+c, with out_ready=1. Beat k must have lane r = 16*r+k (beat 0 lanes = 0,16,...,112). out_last must be high on beat 7 only. First beat appears the cycle after row 7 is accepted.
- Back-to-back: 4 blocks streamed with in_valid=out_ready=1. Required:
  - in_ready never drops after reset;
  - 32 output beats in 32 consecutive cycles starting at cycle 8;
  - each block is correctly transposed, with element(b,r,c)=256*b+16*r+c.
- Backpressure: out_ready=0 while 3 blocks are offered. Required:
  - block 0 and block 1 are accepted;
  - in_ready=0 after 16 beats;
  - out_data holds beat 0 of block 0 stable.
  - After out_ready is released, blocks 0, 1 and 2 emerge in order with no loss.
- Bypass mix: block 0 with in_bypass=1, then block 1 with in_bypass=0, and in_bypass toggled mid-block. Required:
  - block 0 output beat k equals input row k;
  - block 1 is transposed;
  - the mid-block toggle is ignored.
- Random valid/ready: 50% random in_valid and out_ready over 200 blocks. A scoreboard must match every beat, and out_last must mark every 8th consumed beat.
- Reset mid-operation: assert rstn=0 after 5 rows of block 0 and 3 beats of a previous block. Required:
  - outputs immediately show in_ready=1, out_valid=0, out_data=0;
  - the next full block is transposed correctly, with no residue from the earlier blocks.
